// File: rtl/rs232_ctrl_arbiter.sv
// rtl/rs232_ctrl_arbiter.sv - two-master round-robin arbiter for the rs232 UART control port (optional watchdog: RS232_ARB_TIMEOUT_EN)
module rs232_ctrl_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  m0_wr,
    input  logic        m0_rd,
    input  logic [15:0] m0_addr,
    input  logic [31:0] m0_wdat,
    output logic [31:0] m0_rdat,
    output logic        m0_done,
    output logic        m0_err,
    input  logic [3:0]  m1_wr,
    input  logic        m1_rd,
    input  logic [15:0] m1_addr,
    input  logic [31:0] m1_wdat,
    output logic [31:0] m1_rdat,
    output logic        m1_done,
    output logic        m1_err,
    output logic [3:0]  s_wr,
    output logic        s_rd,
    output logic [15:0] s_addr,
    output logic [31:0] s_wdat,
    input  logic [31:0] s_rdat,
    input  logic        s_done,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic        last_q;
    logic        owner_q;
    logic [1:0]  grant_q;
    logic [3:0]  s_wr_q;
    logic        s_rd_q;
    logic [15:0] s_addr_q;
    logic [31:0] s_wdat_q;
    logic [31:0] m0_rdat_q;
    logic [31:0] m1_rdat_q;
    logic        m0_done_q;
    logic        m1_done_q;

    logic        req0;
    logic        req1;
    logic        pick_d;

`ifdef RS232_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wdog_q;
    logic             m0_err_q;
    logic             m1_err_q;
`endif

    assign req0 = (|m0_wr) || m0_rd;
    assign req1 = (|m1_wr) || m1_rd;

    // Winner selection: a lone requester wins, a tie goes to the master that was not granted last.
    always_comb begin
        pick_d = 1'b0;
        if (req0 && req1) begin
            pick_d = ~last_q;
        end else begin
            pick_d = req1;
        end
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            grant_q   <= 2'b00;
            s_wr_q    <= 4'h0;
            s_rd_q    <= 1'b0;
            s_addr_q  <= 16'h0000;
            s_wdat_q  <= 32'h0000_0000;
            m0_rdat_q <= 32'h0000_0000;
            m1_rdat_q <= 32'h0000_0000;
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
`ifdef RS232_ARB_TIMEOUT_EN
            wdog_q    <= '0;
            m0_err_q  <= 1'b0;
            m1_err_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        owner_q  <= pick_d;
                        last_q   <= pick_d;
                        grant_q  <= pick_d ? 2'b10 : 2'b01;
                        s_wr_q   <= pick_d ? m1_wr   : m0_wr;
                        s_rd_q   <= pick_d ? m1_rd   : m0_rd;
                        s_addr_q <= pick_d ? m1_addr : m0_addr;
                        s_wdat_q <= pick_d ? m1_wdat : m0_wdat;
`ifdef RS232_ARB_TIMEOUT_EN
                        wdog_q   <= '0;
`endif
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A completion on the same edge as the watchdog expiry takes priority.
                    if (s_done) begin
                        s_wr_q  <= 4'h0;
                        s_rd_q  <= 1'b0;
                        state_q <= ST_DONE;
                        if (owner_q) begin
                            m1_rdat_q <= s_rdat;
                            m1_done_q <= 1'b1;
                        end else begin
                            m0_rdat_q <= s_rdat;
                            m0_done_q <= 1'b1;
                        end
                    end
`ifdef RS232_ARB_TIMEOUT_EN
                    else if (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        s_wr_q  <= 4'h0;
                        s_rd_q  <= 1'b0;
                        state_q <= ST_DONE;
                        if (owner_q) begin
                            m1_rdat_q <= 32'hFFFF_FFFF;
                            m1_done_q <= 1'b1;
                            m1_err_q  <= 1'b1;
                        end else begin
                            m0_rdat_q <= 32'hFFFF_FFFF;
                            m0_done_q <= 1'b1;
                            m0_err_q  <= 1'b1;
                        end
                    end else begin
                        wdog_q <= wdog_q + CNT_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    // One dead cycle so the finished master can drop its request before IDLE samples it.
                    m0_done_q <= 1'b0;
                    m1_done_q <= 1'b0;
                    grant_q   <= 2'b00;
`ifdef RS232_ARB_TIMEOUT_EN
                    m0_err_q  <= 1'b0;
                    m1_err_q  <= 1'b0;
`endif
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_wr    = s_wr_q;
    assign s_rd    = s_rd_q;
    assign s_addr  = s_addr_q;
    assign s_wdat  = s_wdat_q;
    assign grant   = grant_q;
    assign m0_rdat = m0_rdat_q;
    assign m1_rdat = m1_rdat_q;
    assign m0_done = m0_done_q;
    assign m1_done = m1_done_q;

`ifdef RS232_ARB_TIMEOUT_EN
    assign m0_err  = m0_err_q;
    assign m1_err  = m1_err_q;
`else
    assign m0_err  = 1'b0;
    assign m1_err  = 1'b0;
`endif

endmodule

// File: tb/tb_rs232_ctrl_arbiter.sv
// tb/tb_rs232_ctrl_arbiter.sv - self-checking bench for rs232_ctrl_arbiter
module tb_rs232_ctrl_arbiter;

    localparam int TO = 8;

    typedef struct {
        logic [3:0]  wr;
        logic        rd;
        logic [15:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
    } txn_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  m0_wr, m1_wr;
    logic        m0_rd, m1_rd;
    logic [15:0] m0_addr, m1_addr;
    logic [31:0] m0_wdat, m1_wdat;
    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_done, m1_done, m0_err, m1_err;
    logic [3:0]  s_wr;
    logic        s_rd;
    logic [15:0] s_addr;
    logic [31:0] s_wdat;
    logic [31:0] s_rdat = 32'h0;
    logic        s_done = 1'b0;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;
    int exp_last;
    logic stall, stray;

    txn_t       sl_t;
    txn_t       sl_log[$];
    logic [7:0] tx_q[$];
    int         order_q[$];
    int         done_cnt [2] = '{0, 0};
    int         err_cnt = 0;
    int         bad_grant = 0;

    logic [3:0]  rq_wr   [2];
    logic        rq_rd   [2];
    logic [15:0] rq_addr [2];
    logic [31:0] rq_wdat [2];
    int          lat_r   [2];
    logic [31:0] rdat_r  [2];
    logic        err_r   [2];

    always #5 clk = ~clk;

    rs232_ctrl_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn),
        .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr), .m0_wdat(m0_wdat),
        .m0_rdat(m0_rdat), .m0_done(m0_done), .m0_err(m0_err),
        .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr), .m1_wdat(m1_wdat),
        .m1_rdat(m1_rdat), .m1_done(m1_done), .m1_err(m1_err),
        .s_wr(s_wr), .s_rd(s_rd), .s_addr(s_addr), .s_wdat(s_wdat),
        .s_rdat(s_rdat), .s_done(s_done), .grant(grant)
    );

    function automatic logic [31:0] reg_value(input logic [15:0] a);
        if (a == 16'h0008) return 32'd255;
        else if (a == 16'h0004) return 32'd0;
        else return $urandom;
    endfunction

    // UART control-port model: done one cycle after a request, requests ignored while done is high.
    always @(posedge clk) begin
        if (!resetn) begin
            s_done <= 1'b0;
        end else if (stray) begin
            s_done <= 1'b1;
        end else if (s_done) begin
            s_done <= 1'b0;
        end else if (((|s_wr) || s_rd) && !stall) begin
            sl_t.wr   = s_wr;
            sl_t.rd   = s_rd;
            sl_t.addr = s_addr;
            sl_t.wdat = s_wdat;
            sl_t.rdat = reg_value(s_addr);
            sl_log.push_back(sl_t);
            if (s_addr == 16'h0000 && s_wr[0]) tx_q.push_back(s_wdat[7:0]);
            s_rdat <= sl_t.rdat;
            s_done <= 1'b1;
        end
    end

    // Done/err/grant observer.
    always @(negedge clk) begin
        if (m0_done) begin done_cnt[0]++; order_q.push_back(0); end
        if (m1_done) begin done_cnt[1]++; order_q.push_back(1); end
        if (m0_err || m1_err) err_cnt++;
        if (grant == 2'b11) bad_grant++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input logic [3:0] wr, input logic rd,
                         input logic [15:0] addr, input logic [31:0] wdat);
        if (m == 0) begin
            m0_wr = wr; m0_rd = rd; m0_addr = addr; m0_wdat = wdat;
        end else begin
            m1_wr = wr; m1_rd = rd; m1_addr = addr; m1_wdat = wdat;
        end
    endtask

    // One master transaction: raise at a negedge, hold until done, drop, idle one cycle.
    task automatic master_txn(input int m, input logic [3:0] wr, input logic rd,
                              input logic [15:0] addr, input logic [31:0] wdat,
                              output int lat, output logic [31:0] rdat, output logic err);
        logic seen;
        seen = 1'b0; lat = 0; rdat = '0; err = 1'b0;
        drive(m, wr, rd, addr, wdat);
        while (!seen && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if ((m == 0) ? m0_done : m1_done) begin
                seen = 1'b1;
                rdat = (m == 0) ? m0_rdat : m1_rdat;
                err  = (m == 0) ? m0_err : m1_err;
            end
        end
        drive(m, 4'h0, 1'b0, addr, wdat);
        if (!seen) lat = -1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_txn(input string tag, input int m, input int exp_lat);
        txn_t t;
        check({tag, "_lat"}, lat_r[m], exp_lat);
        check({tag, "_err"}, {31'd0, err_r[m]}, 32'd0);
        checks++;
        assert (sl_log.size() > 0) else begin
            errors++;
            $error("FAIL %s_log: observed=empty expected=one_entry", tag);
        end
        if (sl_log.size() > 0) begin
            t = sl_log.pop_front();
            check({tag, "_fwd"}, {11'd0, t.wr, t.rd, t.addr}, {11'd0, rq_wr[m], rq_rd[m], rq_addr[m]});
            check({tag, "_wdat"}, t.wdat, rq_wdat[m]);
            check({tag, "_rdat"}, rdat_r[m], t.rdat);
        end
    endtask

    // Issue the staged requests of the masters in mask together and score them against round-robin order.
    task automatic run_round(input logic [1:0] mask, input string tag);
        int first;
        int second;
        order_q.delete();
        lat_r[0] = 0; lat_r[1] = 0;
        fork
            begin
                if (mask[0]) master_txn(0, rq_wr[0], rq_rd[0], rq_addr[0], rq_wdat[0], lat_r[0], rdat_r[0], err_r[0]);
            end
            begin
                if (mask[1]) master_txn(1, rq_wr[1], rq_rd[1], rq_addr[1], rq_wdat[1], lat_r[1], rdat_r[1], err_r[1]);
            end
        join
        if (mask == 2'b11) begin
            first  = (exp_last == 1) ? 0 : 1;
            second = 1 - first;
        end else begin
            first  = mask[1] ? 1 : 0;
            second = -1;
        end
        exp_last = (second >= 0) ? second : first;
        check({tag, "_ndone"}, order_q.size(), (second >= 0) ? 2 : 1);
        check({tag, "_first"}, (order_q.size() > 0) ? order_q[0] : -1, first);
        check_txn({tag, "_a"}, first, 3);
        if (second >= 0) begin
            check({tag, "_second"}, (order_q.size() > 1) ? order_q[1] : -1, second);
            check_txn({tag, "_b"}, second, 7);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int base0;
        int base1;
        int a;
        int idx [2];
        int alat0, alat1;
        logic [31:0] ard0, ard1;
        logic aerr0, aerr1;

        drive(0, 4'h0, 1'b0, 16'h0, 32'h0);
        drive(1, 4'h0, 1'b0, 16'h0, 32'h0);
        stall = 1'b0; stray = 1'b0; resetn = 1'b0; exp_last = 1;
        repeat (2) @(negedge clk);

        check("rst_grant", {30'd0, grant}, 32'd0);
        check("rst_s_wr", {28'd0, s_wr}, 32'd0);
        check("rst_s_rd", {31'd0, s_rd}, 32'd0);
        check("rst_s_addr", {16'd0, s_addr}, 32'd0);
        check("rst_m0_done", {31'd0, m0_done}, 32'd0);
        check("rst_m1_done", {31'd0, m1_done}, 32'd0);
        check("rst_m0_rdat", m0_rdat, 32'd0);
        check("rst_m0_err", {31'd0, m0_err}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Simultaneous writes after reset: M0 first, then M1.
        tx_q.delete();
        rq_wr[0] = 4'h1; rq_rd[0] = 1'b0; rq_addr[0] = 16'h0; rq_wdat[0] = 32'h41;
        rq_wr[1] = 4'h1; rq_rd[1] = 1'b0; rq_addr[1] = 16'h0; rq_wdat[1] = 32'h42;
        run_round(2'b11, "dual_wr");
        check("dual_tx_n", tx_q.size(), 2);
        check("dual_tx0", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hFFFF_FFFF, 32'h41);
        check("dual_tx1", (tx_q.size() > 1) ? 32'(tx_q[1]) : 32'hFFFF_FFFF, 32'h42);

        // Lone M0 read of send-free.
        rq_wr[0] = 4'h0; rq_rd[0] = 1'b1; rq_addr[0] = 16'h8; rq_wdat[0] = 32'h0;
        run_round(2'b01, "m0_rd08");
        check("m0_rd08_val", rdat_r[0], 32'd255);

        // Both masters stream requests: grants must alternate.
        order_q.delete(); tx_q.delete();
        a = (exp_last == 1) ? 0 : 1;
        fork
            begin
                for (int i = 0; i < 4; i++) master_txn(0, 4'h1, 1'b0, 16'h0, 32'h30 + 32'(i), alat0, ard0, aerr0);
            end
            begin
                for (int j = 0; j < 4; j++) master_txn(1, 4'h1, 1'b0, 16'h0, 32'h50 + 32'(j), alat1, ard1, aerr1);
            end
        join
        check("alt_n", order_q.size(), 8);
        idx[0] = 0; idx[1] = 0;
        for (int k = 0; k < 8; k++) begin
            int em;
            em = (k % 2 == 0) ? a : 1 - a;
            check("alt_order", (k < order_q.size()) ? order_q[k] : -1, em);
            check("alt_tx", (k < tx_q.size()) ? 32'(tx_q[k]) : 32'hFFFF_FFFF,
                  ((em == 0) ? 32'h30 : 32'h50) + 32'(idx[em]));
            idx[em]++;
        end
        check("alt_log_n", sl_log.size(), 8);
        sl_log.delete();
        exp_last = 1 - a;

        // Randomized rounds.
        for (int r = 0; r < 12; r++) begin
            for (int m = 0; m < 2; m++) begin
                rq_wr[m]   = 4'($urandom_range(0, 15));
                rq_rd[m]   = 1'($urandom_range(0, 1));
                if (rq_wr[m] == 4'h0) rq_rd[m] = 1'b1;
                rq_addr[m] = 16'(4 * $urandom_range(0, 2));
                rq_wdat[m] = $urandom;
            end
            run_round(2'($urandom_range(1, 3)), "rand");
        end

        // Stray s_done while idle.
        base0 = done_cnt[0]; base1 = done_cnt[1];
        stray = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_m0", done_cnt[0], base0);
        check("stray_m1", done_cnt[1], base1);
        check("stray_grant", {30'd0, grant}, 32'd0);

`ifdef RS232_ARB_TIMEOUT_EN
        // Watchdog abort with a silent UART.
        stall = 1'b1;
        master_txn(0, 4'h0, 1'b1, 16'h4, 32'h0, lat_r[0], rdat_r[0], err_r[0]);
        check("to_lat", lat_r[0], 1 + TO);
        check("to_err", {31'd0, err_r[0]}, 32'd1);
        check("to_rdat", rdat_r[0], 32'hFFFF_FFFF);
        check("to_log", sl_log.size(), 0);
        stall = 1'b0;
        exp_last = 0;
        base0 = done_cnt[0]; base1 = done_cnt[1];
        stray = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stray = 1'b0;
        repeat (3) @(negedge clk);
        check("to_stray_m0", done_cnt[0], base0);
        check("to_stray_m1", done_cnt[1], base1);
`endif

        // Asynchronous reset in the middle of ISSUE.
        base0 = done_cnt[0];
        drive(0, 4'h0, 1'b1, 16'h8, 32'h0);
        @(posedge clk);
        #1;
        check("pre_rst_s_rd", {31'd0, s_rd}, 32'd1);
        check("pre_rst_grant", {30'd0, grant}, 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("arst_s_rd", {31'd0, s_rd}, 32'd0);
        check("arst_grant", {30'd0, grant}, 32'd0);
        check("arst_m0_done", {31'd0, m0_done}, 32'd0);
        check("arst_m1_done", {31'd0, m1_done}, 32'd0);
        check("arst_s_addr", {16'd0, s_addr}, 32'd0);
        drive(0, 4'h0, 1'b0, 16'h0, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        exp_last = 1;
        repeat (2) @(negedge clk);
        check("arst_no_done", done_cnt[0], base0);
        rq_wr[1] = 4'h0; rq_rd[1] = 1'b1; rq_addr[1] = 16'h8; rq_wdat[1] = 32'h0;
        run_round(2'b10, "post_rst");
        check("post_rst_val", rdat_r[1], 32'd255);

        check("grant_onehot", bad_grant, 0);
`ifdef RS232_ARB_TIMEOUT_EN
        check("err_pulses", err_cnt, 1);
`else
        check("err_pulses", err_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
